univ_shift_deser: RTL and testbench

//  Serial-in/parallel-out receiver: the far end of a serial link fed by a

---
 rtl/univ_shift_deser_pkg.sv | 14 +
 rtl/univ_shift_deser_if.sv | 21 ++
 rtl/univ_shift_deser_shift_collect.sv | 75 +++++++
 rtl/univ_shift_deser.sv | 67 ++++++
 tb/tb_univ_shift_deser.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/univ_shift_deser_pkg.sv
// Shared types and helpers for the serial-in/parallel-out receiver.
package univ_shift_deser_pkg;

  typedef enum logic {
    ORDER_MSB_FIRST = 1'b0,
    ORDER_LSB_FIRST = 1'b1
  } order_e;

  // Bit counter width; a floor of 1 keeps the counter a real vector.
  function automatic int cnt_width(input int dw);
    return (dw < 2) ? 1 : $clog2(dw);
  endfunction

endpackage

// File: rtl/univ_shift_deser_if.sv
// Serial input side and parallel valid/ready output side of the receiver.
interface univ_shift_deser_if #(parameter int DW = 4);
  logic          dir;
  logic          sin_valid;
  logic          sin;
  logic          sin_ready;
  logic [DW-1:0] q;
  logic          q_valid;
  logic          q_ready;
  logic          busy;

  modport master (
    output dir, sin_valid, sin, q_ready,
    input  sin_ready, q, q_valid, busy
  );

  modport slave (
    input  dir, sin_valid, sin, q_ready,
    output sin_ready, q, q_valid, busy
  );
endinterface

// File: rtl/univ_shift_deser_shift_collect.sv
// Shift stage: collects serial bits into sr and parks a completed word
// there while the output stage is still occupied.
module univ_shift_deser_shift_collect
  import univ_shift_deser_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          sync_rst_n,
  input  logic          dir_i,
  input  logic          sin_valid_i,
  input  logic          sin_i,
  input  logic          out_free_i,
  input  logic          drain_i,
  output logic          sin_ready_o,
  output logic          word_done_o,
  output logic [DW-1:0] word_o,
  output logic [DW-1:0] sr_o,
  output logic          sr_full_o,
  output logic          busy_o
);

  localparam int CW = cnt_width(DW);

  logic [DW-1:0] sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  order_e        dir_l_q, dir_l_d;
  logic          sr_full_q, sr_full_d;
  logic          accept;
  logic          last_bit;
  order_e        dir_eff;

  assign accept   = sin_valid_i && !sr_full_q;
  assign last_bit = (cnt_q == CW'(DW - 1));

  always_comb begin
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    dir_l_d   = dir_l_q;
    sr_full_d = sr_full_q;
    // The first bit of a word uses the live dir input, later bits the latched one.
    dir_eff   = (cnt_q == '0) ? order_e'(dir_i) : dir_l_q;
    if (accept) begin
      if (cnt_q == '0) dir_l_d = order_e'(dir_i);
      sr_d  = (dir_eff == ORDER_MSB_FIRST) ? {sr_q[DW-2:0], sin_i}
                                           : {sin_i, sr_q[DW-1:1]};
      cnt_d = last_bit ? '0 : cnt_q + CW'(1);
      if (last_bit && !out_free_i) sr_full_d = 1'b1;
    end else if (drain_i) begin
      sr_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      sr_q      <= '0;
      cnt_q     <= '0;
      dir_l_q   <= ORDER_MSB_FIRST;
      sr_full_q <= 1'b0;
    end else begin
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      dir_l_q   <= dir_l_d;
      sr_full_q <= sr_full_d;
    end
  end

  assign sin_ready_o = !sr_full_q;
  assign word_done_o = accept && last_bit;
  assign word_o      = sr_d;
  assign sr_o        = sr_q;
  assign sr_full_o   = sr_full_q;
  assign busy_o      = (cnt_q != '0);

endmodule

// File: rtl/univ_shift_deser.sv
// Receiver top: output register with valid/ready handshake in front of the
// shift stage, forming a 2-deep word buffer.
module univ_shift_deser
  import univ_shift_deser_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic               clk,
  input  logic               sync_rst_n,
  univ_shift_deser_if.slave  bus
);

  logic [DW-1:0] q_q, q_d;
  logic          q_valid_q, q_valid_d;
  logic          out_free;
  logic          drain;
  logic          word_done;
  logic [DW-1:0] word;
  logic [DW-1:0] sr;
  logic          sr_full;

  assign out_free = !q_valid_q || bus.q_ready;
  assign drain    = q_valid_q && bus.q_ready && sr_full;

  univ_shift_deser_shift_collect #(.DW(DW)) u_collect (
    .clk         (clk),
    .sync_rst_n  (sync_rst_n),
    .dir_i       (bus.dir),
    .sin_valid_i (bus.sin_valid),
    .sin_i       (bus.sin),
    .out_free_i  (out_free),
    .drain_i     (drain),
    .sin_ready_o (bus.sin_ready),
    .word_done_o (word_done),
    .word_o      (word),
    .sr_o        (sr),
    .sr_full_o   (sr_full),
    .busy_o      (bus.busy)
  );

  // A parked word cannot coexist with a completion, since sin_ready is low.
  always_comb begin
    q_d       = q_q;
    q_valid_d = q_valid_q;
    if (word_done && out_free) begin
      q_d       = word;
      q_valid_d = 1'b1;
    end else if (q_valid_q && bus.q_ready) begin
      if (sr_full) q_d = sr;
      else         q_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      q_q       <= '0;
      q_valid_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
    end
  end

  assign bus.q       = q_q;
  assign bus.q_valid = q_valid_q;

endmodule

// File: tb/tb_univ_shift_deser.sv
// Scoreboard bench for univ_shift_deser: the driver pushes each finished
// word's expected value, a monitor pops on every q handshake.
module tb_univ_shift_deser;
  localparam int DW = 4;

  logic clk = 1'b0;
  logic sync_rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   rand_rdy = 1'b0;

  logic [DW-1:0] exp_q[$];
  int            pop_cyc[$];

  univ_shift_deser_if #(.DW(DW)) bus ();

  univ_shift_deser #(.DW(DW)) dut (
    .clk        (clk),
    .sync_rst_n (sync_rst_n),
    .bus        (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: a transfer happens at the next rising edge if valid && ready now.
  initial begin
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (sync_rst_n && bus.q_valid && bus.q_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word: got %0h expected none", bus.q);
        end else begin
          e = exp_q.pop_front();
          check("word", 32'(bus.q), 32'(e));
        end
        pop_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rand_rdy) bus.q_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Called at a falling edge; returns at the falling edge after the bit is taken.
  task automatic send_bit(input logic b, input logic d);
    int   t = 0;
    logic acc;
    bus.sin_valid = 1'b1;
    bus.sin       = b;
    bus.dir       = d;
    forever begin
      acc = bus.sin_ready;
      @(posedge clk);
      @(negedge clk);
      if (acc) break;
      t++;
      if (t > 200) begin
        checks++;
        failures++;
        $display("FAIL send_timeout: got sin_ready=0 expected 1 within 200 clk");
        break;
      end
    end
    bus.sin_valid = 1'b0;
  endtask

  // dmode: 0 keeps dir for later bits, 1 inverts it, 2 randomises it.
  task automatic send_word(input logic [DW-1:0] w, input logic d0, input int dmode, input bit gaps);
    logic b, d;
    for (int i = 0; i < DW; i++) begin
      b = d0 ? w[i] : w[DW-1-i];
      if (i == 0)          d = d0;
      else if (dmode == 0) d = d0;
      else if (dmode == 1) d = !d0;
      else                 d = 1'($urandom_range(0, 1));
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      send_bit(b, d);
    end
    exp_q.push_back(w);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    bus.sin_valid = 1'b0;
    sync_rst_n    = 1'b0;
    repeat (n) @(negedge clk);
    sync_rst_n = 1'b1;
    exp_q.delete();
  endtask

  initial begin
    bus.dir = 1'b0;
    bus.sin_valid = 1'b0;
    bus.sin = 1'b0;
    bus.q_ready = 1'b0;

    // Reset state
    do_reset(2);
    #1;
    check("rst_q", 32'(bus.q), 32'h0);
    check("rst_q_valid", 32'(bus.q_valid), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_sin_ready", 32'(bus.sin_ready), 32'h1);

    // MSB-first, one-cycle latency and one-cycle valid
    @(negedge clk);
    bus.q_ready = 1'b1;
    send_word(4'b1011, 1'b0, 0, 1'b0);
    check("msb_valid", 32'(bus.q_valid), 32'h1);
    check("msb_q", 32'(bus.q), 32'hB);
    @(negedge clk); #1;
    check("msb_valid_drop", 32'(bus.q_valid), 32'h0);

    // LSB-first with dir toggled after the first bit
    @(negedge clk);
    send_word(4'b1101, 1'b1, 1, 1'b0);
    check("lsb_q", 32'(bus.q), 32'hD);
    repeat (2) @(negedge clk);

    // Backpressure
    bus.q_ready = 1'b0;
    send_word(4'hA, 1'b0, 0, 1'b0);
    send_word(4'h5, 1'b0, 0, 1'b0);
    #1;
    check("bp_sin_ready", 32'(bus.sin_ready), 32'h0);
    check("bp_q_held", 32'(bus.q), 32'hA);
    @(negedge clk);
    bus.sin_valid = 1'b1;
    bus.sin = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("bp_busy_stuck", 32'(bus.busy), 32'h0);
    check("bp_still_blocked", 32'(bus.sin_ready), 32'h0);
    @(negedge clk);
    bus.sin_valid = 1'b0;
    bus.q_ready = 1'b1;
    @(negedge clk);
    bus.q_ready = 1'b0;
    #1;
    check("bp_q_second", 32'(bus.q), 32'h5);
    check("bp_valid_kept", 32'(bus.q_valid), 32'h1);
    check("bp_sin_ready_back", 32'(bus.sin_ready), 32'h1);
    @(negedge clk);
    bus.q_ready = 1'b1;
    @(negedge clk);
    bus.q_ready = 1'b0;
    #1;
    check("bp_valid_cleared", 32'(bus.q_valid), 32'h0);
    check("bp_q_not_cleared", 32'(bus.q), 32'h5);

    // Continuous stream, ready always high
    @(negedge clk);
    bus.q_ready = 1'b1;
    pop_cyc.delete();
    send_word(4'h3, 1'b0, 0, 1'b0);
    send_word(4'hC, 1'b0, 0, 1'b0);
    send_word(4'h9, 1'b0, 0, 1'b0);
    repeat (3) @(negedge clk);
    check("stream_count", 32'(pop_cyc.size()), 32'd3);
    if (pop_cyc.size() == 3) begin
      check("stream_gap1", 32'(pop_cyc[1] - pop_cyc[0]), 32'd4);
      check("stream_gap2", 32'(pop_cyc[2] - pop_cyc[1]), 32'd4);
    end

    // Mid-word reset
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    #1;
    check("mid_busy_before", 32'(bus.busy), 32'h1);
    do_reset(1);
    #1;
    check("mid_busy_after", 32'(bus.busy), 32'h0);
    @(negedge clk);
    send_word(4'b0110, 1'b0, 0, 1'b0);
    check("mid_q", 32'(bus.q), 32'h6);
    repeat (2) @(negedge clk);

    // Randomised traffic with random backpressure and random dir noise
    rand_rdy = 1'b1;
    for (int k = 0; k < 60; k++) begin
      send_word(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 2, 1'b1);
    end
    rand_rdy = 1'b0;
    @(negedge clk);
    bus.q_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("final_valid", 32'(bus.q_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
